// File: rtl/debounce_pkg.sv
// Purpose: shared state encoding for the debounce filter.
// Latency: n/a (types only).
// Backpressure: none.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  // A pending state is one where a level change is being qualified.
  function automatic logic is_pending(input db_state_t s);
    return (s == PEND_HI) || (s == PEND_LO);
  endfunction

endpackage

// File: rtl/debounce_filter_sat_counter.sv
// Purpose: saturating event counter; clear takes priority but a same-edge increment still counts.
// Latency: count updates on the edge where inc/clr are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  // Clear-then-count, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= inc ? LP_ONE : '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + LP_ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/debounce_filter.sv
// Purpose: debounce an already-synchronised input into a clean level, rise/fall pulses and a press count.
// Latency: a new level is accepted DEBOUNCE_CYCLES samples after the first differing sample.
// Backpressure: none; every sample is consumed, pulses are single-cycle and unacknowledged.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter int EVT_WIDTH       = 8
) (
  input  logic                 clk_dst,
  input  logic                 rst_dst_n,
  input  logic                 signal_sync,
  input  logic                 clear_evt,
  output logic                 signal_db,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [EVT_WIDTH-1:0] evt_count,
  output logic                 busy
);

  // Last count value before acceptance; the accepting sample is the D-th equal one.
  localparam logic [CNT_WIDTH-1:0] LP_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  db_state_t            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_db;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_busy;
  logic                 w_cnt_last;
  logic                 w_rise_acc;

  assign w_cnt_last = (r_cnt == LP_LAST);
  // The press counter increments on the same edge that launches rise_pulse.
  assign w_rise_acc = (r_state == PEND_HI) && signal_sync && w_cnt_last;

  // Debounce FSM with stability counter; all outputs registered alongside state.
  always_ff @(posedge clk_dst or negedge rst_dst_n) begin
    if (!rst_dst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (signal_sync) begin
            r_state <= PEND_HI;
            r_cnt   <= LP_CNT_ONE;
            r_busy  <= is_pending(PEND_HI);
          end
        end
        PEND_HI: begin
          if (!signal_sync) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_busy  <= is_pending(STABLE_LO);
          end else if (w_cnt_last) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_db    <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= is_pending(STABLE_HI);
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!signal_sync) begin
            r_state <= PEND_LO;
            r_cnt   <= LP_CNT_ONE;
            r_busy  <= is_pending(PEND_LO);
          end
        end
        PEND_LO: begin
          if (signal_sync) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_busy  <= is_pending(STABLE_HI);
          end else if (w_cnt_last) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= is_pending(STABLE_LO);
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_db    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (EVT_WIDTH)
  ) u_evt_cnt (
    .clk   (clk_dst),
    .rst_n (rst_dst_n),
    .inc   (w_rise_acc),
    .clr   (clear_evt),
    .count (evt_count)
  );

  assign signal_db  = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_filter.sv
// Purpose: directed bench for debounce_filter with D=4, 3-bit event counter.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_debounce_filter;

  logic       clk_dst;
  logic       rst_dst_n;
  logic       signal_sync;
  logic       clear_evt;
  logic       signal_db;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [2:0] evt_count;
  logic       busy;

  int n_cmp;
  int n_err;

  debounce_filter #(
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (16),
    .EVT_WIDTH       (3)
  ) dut (
    .clk_dst     (clk_dst),
    .rst_dst_n   (rst_dst_n),
    .signal_sync (signal_sync),
    .clear_evt   (clear_evt),
    .signal_db   (signal_db),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .evt_count   (evt_count),
    .busy        (busy)
  );

  initial clk_dst = 1'b0;
  always #5 clk_dst = ~clk_dst;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic db, input logic rp, input logic fp,
                         input logic bz, input logic [2:0] ev);
    chk($sformatf("%s.db", tag),   {7'd0, signal_db},  {7'd0, db});
    chk($sformatf("%s.rise", tag), {7'd0, rise_pulse}, {7'd0, rp});
    chk($sformatf("%s.fall", tag), {7'd0, fall_pulse}, {7'd0, fp});
    chk($sformatf("%s.busy", tag), {7'd0, busy},       {7'd0, bz});
    chk($sformatf("%s.evt", tag),  {5'd0, evt_count},  {5'd0, ev});
  endtask

  // Advance one sample edge and settle.
  task automatic tick();
    @(posedge clk_dst);
    #1;
  endtask

  // Clean press and release from STABLE_LO; checks the accepting edge.
  task automatic press(input string tag, input logic [2:0] ev_exp);
    signal_sync = 1'b1;
    tick(); tick(); tick();
    tick();
    chk_all(tag, 1'b1, 1'b1, 1'b0, 1'b0, ev_exp);
    signal_sync = 1'b0;
    tick(); tick(); tick();
    tick();
    chk_all({tag, "_rel"}, 1'b0, 1'b0, 1'b1, 1'b0, ev_exp);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_dst_n   = 1'b1;
    signal_sync = 1'b0;
    clear_evt   = 1'b0;
    #1 rst_dst_n = 1'b0;
    #1 chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("rst_edge", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_dst_n = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Glitch: three high samples then low.
    signal_sync = 1'b1;
    tick(); chk_all("gl1", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("gl2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("gl3", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    signal_sync = 1'b0;
    tick(); chk_all("gl4", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(); chk_all("gl5", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Press: accepted on the fourth high sample.
    signal_sync = 1'b1;
    tick(); chk_all("pr1", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("pr2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("pr3", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("pr4", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    tick(); chk_all("pr5", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);

    // Release bounce: 0,1,0,0,0,0.
    signal_sync = 1'b0;
    tick(); chk_all("rb1", 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    signal_sync = 1'b1;
    tick(); chk_all("rb2", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    signal_sync = 1'b0;
    tick(); chk_all("rb3", 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    tick(); chk_all("rb4", 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    tick(); chk_all("rb5", 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    tick(); chk_all("rb6", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    tick(); chk_all("rb7", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);

    // Clear alone, then saturation over 9 presses.
    clear_evt = 1'b1;
    tick(); chk_all("clr0", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    clear_evt = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      press($sformatf("sat%0d", i), (i > 7) ? 3'd7 : 3'(i));
    end
    clear_evt = 1'b1;
    tick(); chk_all("clr1", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    clear_evt = 1'b0;

    // Simultaneous clear and accepted rise with count at 5.
    for (int i = 1; i <= 5; i++) begin
      press($sformatf("pre%0d", i), 3'(i));
    end
    signal_sync = 1'b1;
    tick(); tick(); tick();
    clear_evt = 1'b1;
    tick(); chk_all("simul", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    clear_evt = 1'b0;
    signal_sync = 1'b0;
    tick(); tick(); tick();
    tick(); chk_all("simul_rel", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);

    // Reset in PEND_HI with cnt=2.
    signal_sync = 1'b1;
    tick(); tick(); chk_all("mp_pend", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    rst_dst_n = 1'b0;
    #1 chk_all("mp_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(); chk_all("mp_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(); chk_all("mp_rst_edge2", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_dst_n = 1'b1;
    tick(); chk_all("mp1", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("mp2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("mp3", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick(); chk_all("mp4", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    tick(); chk_all("mp5", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
